// File: rtl/chip8_pkg.sv
// -----------------------------------------------------------------------------
// chip8_pkg
// Shared types and constants for the CHIP-8 single-step / run controller.
//   step_state_t             : instruction-issue FSM state (IDLE, ISSUE, WAIT)
//   DEBOUNCE_CYCLES_DEFAULT  : 10 ms of stable level at 100 MHz
//   CLKS_PER_INSTR_DEFAULT   : 1 kHz run-mode issue rate at 100 MHz
//   COUNT_W_DEFAULT          : retired-instruction counter width
//   cnt_width()              : bits needed to hold the values 0..n-1 (min 1)
// -----------------------------------------------------------------------------
package chip8_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } step_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd1_000_000;
    localparam int unsigned CLKS_PER_INSTR_DEFAULT  = 32'd100_000;
    localparam int unsigned COUNT_W_DEFAULT         = 32'd16;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        cnt_width = 32'd1;
        for (int unsigned i = 32'd1; i < 32'd32; i++) begin
            if ((32'd1 << i) < n) begin
                cnt_width = i + 32'd1;
            end else begin
                cnt_width = cnt_width;
            end
        end
    endfunction

endpackage

// File: rtl/chip8_step_ctrl_if.sv
// -----------------------------------------------------------------------------
// chip8_step_ctrl_if
// Board-button / CPU-enable bundle for chip8_step_ctrl.
//   step_btn_in, run_btn_in : raw, asynchronous buttons (active-high)
//   instr_done_in           : core retire pulse
//   advance_out             : one-cycle "execute one instruction" pulse
//   busy_out                : an instruction is in flight
//   running_out             : run mode active
//   step_count_out          : retired-instruction count (COUNT_W bits)
// Modports: master = the controller, slave = board/core side.
// -----------------------------------------------------------------------------
interface chip8_step_ctrl_if
    import chip8_pkg::*;
#(
    parameter int unsigned COUNT_W = COUNT_W_DEFAULT
);

    logic               step_btn_in;
    logic               run_btn_in;
    logic               instr_done_in;
    logic               advance_out;
    logic               busy_out;
    logic               running_out;
    logic [COUNT_W-1:0] step_count_out;

    modport master (
        input  step_btn_in,
        input  run_btn_in,
        input  instr_done_in,
        output advance_out,
        output busy_out,
        output running_out,
        output step_count_out
    );

    modport slave (
        output step_btn_in,
        output run_btn_in,
        output instr_done_in,
        input  advance_out,
        input  busy_out,
        input  running_out,
        input  step_count_out
    );

endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser, stable-level debouncer and rising-edge detector for
// one mechanical button.
//   clk_in    : system clock
//   rst_in    : asynchronous active-high reset
//   btn_in    : raw asynchronous button level
//   press_out : one-cycle pulse, registered, in the cycle the debounced level
//               rises (2 + DEBOUNCE_CYCLES cycles after the raw press)
// -----------------------------------------------------------------------------
module btn_debounce
    import chip8_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic btn_in,
    output logic press_out
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;

    // Synchroniser, debounce counter and registered rising-edge pulse.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            press_r <= 1'b0;
        end else begin
            sync1_r <= btn_in;
            sync2_r <= sync1_r;
            if (sync2_r != level_r) begin
                // The cycle that completes the stable run flips the level;
                // press fires only on the 0->1 flip.
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync2_r;
                    cnt_r   <= {CNT_W{1'b0}};
                    press_r <= sync2_r;
                end else begin
                    cnt_r   <= cnt_r + CNT_W'(1);
                    press_r <= 1'b0;
                end
            end else begin
                // Agreement with the accepted level restarts the count.
                cnt_r   <= {CNT_W{1'b0}};
                press_r <= 1'b0;
            end
        end
    end

    assign press_out = press_r;

endmodule

// File: rtl/chip8_step_ctrl.sv
// -----------------------------------------------------------------------------
// chip8_step_ctrl
// Turns board step / run buttons into CHIP-8 instruction-advance requests,
// keeping at most one instruction in flight.
//   clk_in : system clock (100 MHz)
//   rst_in : asynchronous active-high reset (released synchronously inside)
//   bus    : chip8_step_ctrl_if.master (buttons, core handshake, status)
// Optional feature macro: STEP_COUNT_EN -- when defined, step_count_out counts
// retired instructions modulo 2^COUNT_W; otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module chip8_step_ctrl
    import chip8_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CLKS_PER_INSTR  = CLKS_PER_INSTR_DEFAULT,
    parameter int unsigned COUNT_W         = COUNT_W_DEFAULT
) (
    input  logic              clk_in,
    input  logic              rst_in,
    chip8_step_ctrl_if.master bus
);

    localparam int unsigned      DIV_W    = cnt_width(CLKS_PER_INSTR);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_INSTR - 32'd1);

    logic [1:0]       rst_sync_r;
    logic             rst_s;
    logic             step_press_s;
    logic             run_press_s;
    logic             running_r;
    logic [DIV_W-1:0] div_r;
    logic             tick_s;
    logic             pending_r;
    step_state_t      state_r;
    step_state_t      state_next_s;
    logic             done_accept_s;
    logic             advance_s;
    logic             busy_s;

    // Reset synchroniser: assertion is immediate, release waits two clocks.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rst_sync_r <= 2'b11;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b0};
        end
    end

    assign rst_s = rst_sync_r[1];

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk_in    (clk_in),
        .rst_in    (rst_s),
        .btn_in    (bus.step_btn_in),
        .press_out (step_press_s)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clk_in    (clk_in),
        .rst_in    (rst_s),
        .btn_in    (bus.run_btn_in),
        .press_out (run_press_s)
    );

    // Run/halt toggle; halting leaves any in-flight instruction alone.
    always_ff @(posedge clk_in or posedge rst_s) begin
        if (rst_s) begin
            running_r <= 1'b0;
        end else if (run_press_s) begin
            running_r <= ~running_r;
        end else begin
            running_r <= running_r;
        end
    end

    // Rate divider: free-runs 0..CLKS_PER_INSTR-1 in run mode, parked at 0 otherwise.
    always_ff @(posedge clk_in or posedge rst_s) begin
        if (rst_s) begin
            div_r <= {DIV_W{1'b0}};
        end else if (!running_r || (div_r == DIV_LAST)) begin
            div_r <= {DIV_W{1'b0}};
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    assign tick_s = running_r && (div_r == DIV_LAST);

    // Single-entry request flag; requests arriving while it is set are dropped.
    // Step presses count only when halted (covers a press coinciding with a
    // halting run press, since running_r is still 1 in that cycle).
    always_ff @(posedge clk_in or posedge rst_s) begin
        if (rst_s) begin
            pending_r <= 1'b0;
        end else if ((state_r == IDLE) && pending_r) begin
            pending_r <= 1'b0;
        end else if ((step_press_s && !running_r) || tick_s) begin
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Retire pulses only count while waiting; ISSUE-cycle pulses are ignored.
    assign done_accept_s = (state_r == WAIT) && bus.instr_done_in;

    // FSM state register.
    always_ff @(posedge clk_in or posedge rst_s) begin
        if (rst_s) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (pending_r) begin
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                state_next_s = WAIT;
            end
            WAIT: begin
                if (done_accept_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM outputs, decoded purely from the state register.
    always_comb begin
        advance_s = 1'b0;
        busy_s    = 1'b0;
        case (state_r)
            IDLE: begin
                advance_s = 1'b0;
                busy_s    = 1'b0;
            end
            ISSUE: begin
                advance_s = 1'b1;
                busy_s    = 1'b1;
            end
            WAIT: begin
                advance_s = 1'b0;
                busy_s    = 1'b1;
            end
            default: begin
                advance_s = 1'b0;
                busy_s    = 1'b0;
            end
        endcase
    end

    assign bus.advance_out = advance_s;
    assign bus.busy_out    = busy_s;
    assign bus.running_out = running_r;

`ifdef STEP_COUNT_EN
    logic [COUNT_W-1:0] step_count_r;

    // Retired-instruction counter for the debug display; wraps naturally.
    always_ff @(posedge clk_in or posedge rst_s) begin
        if (rst_s) begin
            step_count_r <= {COUNT_W{1'b0}};
        end else if (done_accept_s) begin
            step_count_r <= step_count_r + COUNT_W'(1);
        end else begin
            step_count_r <= step_count_r;
        end
    end

    assign bus.step_count_out = step_count_r;
`else
    assign bus.step_count_out = {COUNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_chip8_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_chip8_step_ctrl
// Directed bench for chip8_step_ctrl with DEBOUNCE_CYCLES=4, CLKS_PER_INSTR=10.
// A raw button asserted in cycle 0 gives a press event in cycle 6 and an
// advance_out in cycle 8. A small core model answers each advance_out with
// instr_done_in core_lat cycles later.
// -----------------------------------------------------------------------------
module tb_chip8_step_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   core_lat = 3;
    int   core_cnt = 0;
    int   overlap_n = 0;
    logic prev_busy = 1'b0;

    chip8_step_ctrl_if #(.COUNT_W(16)) bus ();

    chip8_step_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CLKS_PER_INSTR  (10),
        .COUNT_W         (16)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Core model: retire core_lat cycles after each advance.
    always begin
        @(posedge clk);
        #1;
        bus.instr_done_in = 1'b0;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) bus.instr_done_in = 1'b1;
        end
        if (bus.advance_out === 1'b1) core_cnt = core_lat;
    end

    // Records any advance that follows a cycle with busy already high.
    always begin
        @(posedge clk);
        #1;
        if ((bus.advance_out === 1'b1) && prev_busy) overlap_n++;
        prev_busy = (bus.busy_out === 1'b1);
    end

    function automatic logic [15:0] exp_cnt(input int n);
`ifdef STEP_COUNT_EN
        return 16'(n);
`else
        return 16'd0;
`endif
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.step_btn_in = 1'b0;
        bus.run_btn_in  = 1'b0;
        #19;
        checks++; if (bus.advance_out !== 1'b0) begin errors++; $display("FAIL rst_advance: got %b want 0", bus.advance_out); end
        checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy_out); end
        checks++; if (bus.running_out !== 1'b0) begin errors++; $display("FAIL rst_running: got %b want 0", bus.running_out); end
        checks++; if (bus.step_count_out !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", bus.step_count_out); end
        #1 rst = 1'b0;
        repeat (3) next_cycle();
        checks++;
        if ({bus.advance_out, bus.busy_out, bus.running_out} !== 3'b000) begin
            errors++; $display("FAIL post_rst_outputs: got %b want 000", {bus.advance_out, bus.busy_out, bus.running_out});
        end
    endtask

    task automatic test_single_step();
        int adv_at = -1;
        int adv_n = 0;
        int busy_n = 0;
        core_lat = 3;
        bus.step_btn_in = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            next_cycle();
            if (c == 10) bus.step_btn_in = 1'b0;
            if (bus.advance_out === 1'b1) begin adv_n++; adv_at = c; end
            if (bus.busy_out === 1'b1) busy_n++;
        end
        checks++; if (adv_at != 8) begin errors++; $display("FAIL single_adv_cycle: got %0d want 8", adv_at); end
        checks++; if (adv_n != 1) begin errors++; $display("FAIL single_adv_count: got %0d want 1", adv_n); end
        checks++; if (busy_n != 4) begin errors++; $display("FAIL single_busy_len: got %0d want 4", busy_n); end
        checks++; if (bus.step_count_out !== exp_cnt(1)) begin errors++; $display("FAIL single_count: got %0d want %0d", bus.step_count_out, exp_cnt(1)); end
    endtask

    task automatic test_bounce();
        int adv_at = -1;
        int adv_n = 0;
        core_lat = 3;
        bus.step_btn_in = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            next_cycle();
            if (c < 12) bus.step_btn_in = (((c / 2) % 2) == 0) ? 1'b1 : 1'b0;
            else if (c < 30) bus.step_btn_in = 1'b1;
            else bus.step_btn_in = 1'b0;
            if (bus.advance_out === 1'b1) begin
                adv_n++;
                if (adv_at < 0) adv_at = c;
            end
        end
        checks++; if (adv_at != 20) begin errors++; $display("FAIL bounce_adv_cycle: got %0d want 20", adv_at); end
        checks++; if (adv_n != 1) begin errors++; $display("FAIL bounce_adv_count: got %0d want 1", adv_n); end
    endtask

    task automatic test_presses_during_wait();
        int adv_c[2] = '{-1, -1};
        int adv_n = 0;
        logic busy_39 = 1'b1;
        core_lat = 30;
        bus.step_btn_in = 1'b1;
        for (int c = 1; c <= 75; c++) begin
            next_cycle();
            if (c == 6 || c == 20 || c == 30) bus.step_btn_in = 1'b0;
            if (c == 14 || c == 24) bus.step_btn_in = 1'b1;
            if (bus.advance_out === 1'b1) begin
                if (adv_n < 2) adv_c[adv_n] = c;
                adv_n++;
            end
            if (c == 39) busy_39 = bus.busy_out;
        end
        checks++; if (adv_n != 2) begin errors++; $display("FAIL wait_adv_count: got %0d want 2", adv_n); end
        checks++; if (adv_c[0] != 8) begin errors++; $display("FAIL wait_first_adv: got %0d want 8", adv_c[0]); end
        checks++; if (adv_c[1] != 40) begin errors++; $display("FAIL wait_second_adv: got %0d want 40", adv_c[1]); end
        checks++; if (busy_39 !== 1'b0) begin errors++; $display("FAIL wait_busy_drop: got %b want 0", busy_39); end
        checks++; if (bus.step_count_out !== exp_cnt(4)) begin errors++; $display("FAIL wait_count: got %0d want %0d", bus.step_count_out, exp_cnt(4)); end
    endtask

    task automatic test_run_mode();
        int first = -1;
        int last = -1;
        int adv_n = 0;
        logic run_7 = 1'b0;
        logic run_108 = 1'b1;
        logic busy_110 = 1'b1;
        core_lat = 1;
        bus.run_btn_in = 1'b1;
        for (int c = 1; c <= 140; c++) begin
            next_cycle();
            if (c == 6 || c == 107) bus.run_btn_in = 1'b0;
            if (c == 101) bus.run_btn_in = 1'b1;
            if (c == 44) bus.step_btn_in = 1'b1;
            if (c == 50) bus.step_btn_in = 1'b0;
            if (bus.advance_out === 1'b1) begin
                adv_n++;
                if (first < 0) first = c;
                last = c;
            end
            if (c == 7) run_7 = bus.running_out;
            if (c == 108) run_108 = bus.running_out;
            if (c == 110) busy_110 = bus.busy_out;
        end
        checks++; if (run_7 !== 1'b1) begin errors++; $display("FAIL run_start: got %b want 1", run_7); end
        checks++; if (adv_n != 10) begin errors++; $display("FAIL run_adv_count: got %0d want 10", adv_n); end
        checks++; if (first != 18) begin errors++; $display("FAIL run_first_adv: got %0d want 18", first); end
        checks++; if (last != 108) begin errors++; $display("FAIL run_last_adv: got %0d want 108", last); end
        checks++; if (run_108 !== 1'b0) begin errors++; $display("FAIL run_halt: got %b want 0", run_108); end
        checks++; if (busy_110 !== 1'b0) begin errors++; $display("FAIL run_inflight_done: got %b want 0", busy_110); end
        checks++; if (bus.step_count_out !== exp_cnt(14)) begin errors++; $display("FAIL run_count: got %0d want %0d", bus.step_count_out, exp_cnt(14)); end
    endtask

    task automatic test_run_stall();
        int adv_c[4] = '{-1, -1, -1, -1};
        int adv_n = 0;
        core_lat = 25;
        bus.run_btn_in = 1'b1;
        for (int c = 1; c <= 150; c++) begin
            next_cycle();
            if (c == 6 || c == 86) bus.run_btn_in = 1'b0;
            if (c == 80) bus.run_btn_in = 1'b1;
            if (c == 50) bus.step_btn_in = 1'b1;
            if (c == 56) bus.step_btn_in = 1'b0;
            if (bus.advance_out === 1'b1) begin
                if (adv_n < 4) adv_c[adv_n] = c;
                adv_n++;
            end
        end
        checks++; if (adv_n != 4) begin errors++; $display("FAIL stall_adv_count: got %0d want 4", adv_n); end
        checks++;
        if (adv_c[0] != 18 || adv_c[1] != 45 || adv_c[2] != 72 || adv_c[3] != 99) begin
            errors++; $display("FAIL stall_adv_cycles: got %0d %0d %0d %0d want 18 45 72 99", adv_c[0], adv_c[1], adv_c[2], adv_c[3]);
        end
        checks++; if (overlap_n != 0) begin errors++; $display("FAIL no_overlap: got %0d overlaps want 0", overlap_n); end
        checks++; if (bus.running_out !== 1'b0) begin errors++; $display("FAIL stall_halted: got %b want 0", bus.running_out); end
    endtask

    task automatic test_reset_mid_wait();
        int adv_n = 0;
        int busy_n = 0;
        logic busy_async;
        core_lat = 30;
        bus.step_btn_in = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            next_cycle();
            if (c == 6) bus.step_btn_in = 1'b0;
            if (c == 12) begin
                #2 rst = 1'b1;
                #1 busy_async = bus.busy_out;
                checks++; if (busy_async !== 1'b0) begin errors++; $display("FAIL rst_mid_wait_busy: got %b want 0", busy_async); end
                #3 rst = 1'b0;
            end
            if (c > 12) begin
                if (bus.advance_out === 1'b1) adv_n++;
                if (bus.busy_out === 1'b1) busy_n++;
            end
        end
        checks++; if (adv_n != 0) begin errors++; $display("FAIL rst_mid_wait_adv: got %0d want 0", adv_n); end
        checks++; if (busy_n != 0) begin errors++; $display("FAIL rst_mid_wait_late_done: got %0d busy cycles want 0", busy_n); end
        checks++; if (bus.step_count_out !== 16'd0) begin errors++; $display("FAIL rst_mid_wait_count: got %0d want 0", bus.step_count_out); end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_bounce();
        test_presses_during_wait();
        test_run_mode();
        test_run_stall();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chip8_step_ctrl.md
Name: chip8_step_ctrl

Overview:
- Receiving end of the board button interface: turns raw `btn` presses into CPU instruction-advance requests for the CHIP-8 core.
- Synchronises, debounces and edge-detects a step button and a run/halt button.
- Issues one `advance_out` pulse per step press, or one per rate tick in run mode.
- Handshakes with the core's `instr_done_in` so that at most one instruction is in flight. Sits between `top_level` button inputs and the CPU enable.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronised cycles required before a button level is accepted (10 ms at 100 MHz); ≥1.
- CLKS_PER_INSTR, 100_000, run-mode issue period in clk_in cycles (1 kHz); ≥2.
- COUNT_W, 16, width of step_count_out.

Ports:
- clk_in  input  1  system clock, 100 MHz
- rst_in  input  1  asynchronous, active-high reset
- step_btn_in  input  1  raw step button, asynchronous, active-high
- run_btn_in  input  1  raw run/halt toggle button, asynchronous, active-high
- instr_done_in  input  1  one-cycle pulse from core when the issued instruction retires
- advance_out  output  1  one-cycle pulse: core executes one instruction
- busy_out  output  1  high from the advance_out cycle until instr_done_in is accepted
- running_out  output  1  run mode active
- step_count_out  output  COUNT_W  retired instructions (only with STEP_COUNT_EN)

Behaviour:
- Reset (async assert, sync release): all outputs 0; synchronisers 0; debounced levels 0; counters 0; pending flags 0; FSM=IDLE.
- Input conditioning:
  - Each button passes through a 2-flop synchroniser.
  - The debounced level updates only after DEBOUNCE_CYCLES consecutive cycles with the synchronised value differing from the current debounced level. Any bounce restarts the count.
  - A press is the 0→1 edge of the debounced level, one cycle wide.
  - Minimum latency from raw press to press event: 2 + DEBOUNCE_CYCLES cycles.
- Run toggle: a run press toggles running_out on the next cycle. Halting does not abort an in-flight instruction.
- Rate divider:
  - Counts 0..CLKS_PER_INSTR-1 only while running_out=1 and wraps.
  - Emits a tick when the count equals CLKS_PER_INSTR-1.
  - Cleared to 0 whenever running_out=0.
- Pending flag:
  - Set by a step press while running_out=0, or by a tick while running_out=1.
  - Cleared when the FSM leaves IDLE.
  - Holds a single request; further presses or ticks while it is set are dropped (no queueing).
  - Step presses during run mode are ignored.
  - A step press in the same cycle as a halting run press is ignored.
- FSM:
  - IDLE: if pending → ISSUE.
  - ISSUE: advance_out=1 and busy_out=1 for exactly one cycle → WAIT.
  - WAIT: busy_out=1; on instr_done_in → IDLE, and busy_out drops the following cycle.
- Latency: a pending flag set in cycle N gives advance_out in cycle N+2.
- instr_done_in outside WAIT is ignored.
- instr_done_in in the ISSUE cycle is ignored: the core must not retire in the same cycle it is advanced.
- advance_out never asserts while busy_out is high from a previous issue.
- Reset mid-WAIT: FSM returns to IDLE immediately; a later instr_done_in is ignored.

Optional Feature:
- Macro: STEP_COUNT_EN.
- Defined:
  - step_count_out increments on every accepted instr_done_in in WAIT.
  - Wraps modulo 2^COUNT_W; reset to 0.
  - Used by the debug seven-segment display.
- Undefined:
  - Port present but tied to 0.
  - No counter flops.

Decomposition:
- Package `chip8_pkg`:
  - step FSM state enum (IDLE, ISSUE, WAIT);
  - default constants DEBOUNCE_CYCLES_DEFAULT, CLKS_PER_INSTR_DEFAULT.
- Sub-module `btn_debounce`:
  - contains the synchroniser, debounce counter and rising-edge pulse;
  - parameterised by DEBOUNCE_CYCLES;
  - instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4, CLKS_PER_INSTR=10):
- Reset with rst_in=1 for 20 ns → all outputs 0; assert rst_in mid-WAIT → busy_out falls asynchronously.
- Step held 10 cycles, instr_done_in 3 cycles after advance → exactly one advance_out at press+8 cycles; busy_out high 4 cycles; count=1.
- Step toggling every 2 cycles for 12 cycles, then held → no advance during bounce; one advance after stable.
- Two step presses during WAIT → only one further advance after instr_done_in; total 2.
- Run press, core answering instr_done_in 1 cycle after each advance, for 100 cycles → advance every 10 cycles (10 total); second run press halts; the in-flight instruction completes.
- Run mode with core stalling 25 cycles → ticks dropped; advances spaced by core latency, never overlapping busy_out; step presses ignored.
